// File: rtl/adder_pkg.sv
// Shared sizing helpers for the block-partitioned adders and subtractors.
// Blocks are SIZE bits wide, except the last, which takes the remainder.
package adder_pkg;

   function automatic int num_blk(input int width, input int size);
      return (width + size - 1) / size;
   endfunction

   function automatic int blk_width(input int width, input int size, input int k);
      int nb;
      nb = num_blk(width, size);
      return (k < nb - 1) ? size : width - (nb - 1) * size;
   endfunction

endpackage

// File: rtl/pipelined_carry_select_subtractor_csel.sv
// One carry-select block: both carry-in hypotheses are added in parallel and
// the real carry-in picks the matching sum and carry-out.
module csel_sub_block #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W-1:0] sum0, sum1;
   logic         c0, c1;

   Ripple_Carry_Adder #(.W(W)) u_rca0 (.a(a), .b(b), .cin(1'b0), .sum(sum0), .cout(c0));
   Ripple_Carry_Adder #(.W(W)) u_rca1 (.a(a), .b(b), .cin(1'b1), .sum(sum1), .cout(c1));

   assign sum  = cin ? sum1 : sum0;
   assign cout = cin ? c1 : c0;

endmodule

// File: rtl/ripple_carry_adder.sv
// Plain W-bit ripple-carry adder with carry-in and carry-out.
module Ripple_Carry_Adder #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic c;

   always_comb begin
      c   = cin;
      sum = '0;
      for (int i = 0; i < W; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/pipelined_carry_select_subtractor.sv
// a - b - bin as a + ~b + ~bin, one carry-select block per pipeline stage.
// Operands and partial differences travel with each entry; valid bits gate output.
module pipelined_carry_select_subtractor
   import adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SIZE  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int NUM_BLK = num_blk(WIDTH, SIZE);
   localparam int MSB     = WIDTH - 1;

   logic [WIDTH-1:0] a_s    [NUM_BLK];
   logic [WIDTH-1:0] b_s    [NUM_BLK];
   logic [WIDTH-1:0] diff_s [NUM_BLK];
   logic             carry_s[NUM_BLK];
   logic             valid_s[NUM_BLK];
   logic             advance;

   // Whole pipeline moves in lockstep; a held result freezes every stage.
   assign advance   = !valid_s[NUM_BLK-1] | out_ready;
   assign in_ready  = advance;
   assign out_valid = valid_s[NUM_BLK-1];
   assign diff      = diff_s[NUM_BLK-1];

   for (genvar gi = 0; gi < NUM_BLK; gi++) begin : g_stage
      localparam int LO = gi * SIZE;
      localparam int BW = blk_width(WIDTH, SIZE, gi);

      logic [WIDTH-1:0] a_in, b_in, diff_in;
      logic             c_in, v_in;
      logic [BW-1:0]    nb_slice, sum;
      logic             cout;
      logic [WIDTH-1:0] a_d, a_q, b_d, b_q, diff_d, diff_q;
      logic             carry_d, carry_q, valid_d, valid_q;

      if (gi == 0) begin : g_head
         assign a_in    = a;
         assign b_in    = b;
         assign diff_in = '0;
         assign c_in    = ~bin;
         assign v_in    = in_valid;
      end else begin : g_body
         assign a_in    = a_s[gi-1];
         assign b_in    = b_s[gi-1];
         assign diff_in = diff_s[gi-1];
         assign c_in    = carry_s[gi-1];
         assign v_in    = valid_s[gi-1];
      end

      assign nb_slice = ~b_in[LO +: BW];

      csel_sub_block #(.W(BW)) u_blk (
         .a    (a_in[LO +: BW]),
         .b    (nb_slice),
         .cin  (c_in),
         .sum  (sum),
         .cout (cout)
      );

      always_comb begin
         a_d                = a_in;
         b_d                = b_in;
         diff_d             = diff_in;
         diff_d[LO +: BW]   = sum;
         carry_d            = cout;
         valid_d            = v_in;
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            diff_q  <= '0;
         end else if (advance) begin
            valid_q <= valid_d;
            diff_q  <= diff_d;
         end
      end

      // Skew registers carry no reset: a cleared valid bit makes them irrelevant.
      always_ff @(posedge clk) begin
         if (advance) begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
         end
      end

      assign a_s[gi]     = a_q;
      assign b_s[gi]     = b_q;
      assign diff_s[gi]  = diff_q;
      assign carry_s[gi] = carry_q;
      assign valid_s[gi] = valid_q;

      if (gi == NUM_BLK - 1) begin : g_out
         logic bout_d, bout_q, ovf_d, ovf_q;

         always_comb begin
            bout_d = ~cout;
            ovf_d  = (a_in[MSB] != b_in[MSB]) & (diff_d[MSB] != a_in[MSB]);
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               bout_q <= 1'b0;
               ovf_q  <= 1'b0;
            end else if (advance) begin
               bout_q <= bout_d;
               ovf_q  <= ovf_d;
            end
         end

         assign bout = bout_q;
         assign ovf  = ovf_q;
      end
   end

endmodule

// File: tb/tb_pipelined_carry_select_subtractor.sv
// Drives a 32-bit (8 blocks of 4) and a 30-bit (last block 2 bits) subtractor in
// lockstep; directed vectors, a long stream, a stall and a mid-flight reset.
module tb_pipelined_carry_select_subtractor;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, out_ready, bin;
   logic [31:0] a, b;
   logic        in_ready0, out_valid0, bout0, ovf0;
   logic [31:0] diff0;
   logic        in_ready1, out_valid1, bout1, ovf1;
   logic [29:0] diff1;

   always #5 clk = ~clk;

   pipelined_carry_select_subtractor #(.WIDTH(32), .SIZE(4)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid0), .out_ready(out_ready),
      .diff(diff0), .bout(bout0), .ovf(ovf0)
   );

   pipelined_carry_select_subtractor #(.WIDTH(30), .SIZE(4)) u_dut30 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a[29:0]), .b(b[29:0]), .bin(bin), .out_valid(out_valid1), .out_ready(out_ready),
      .diff(diff1), .bout(bout1), .ovf(ovf1)
   );

   typedef struct {
      logic [31:0] diff;
      logic        bout;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_cmp = 0, n_err = 0;
   int   cyc = 0, acc = 0, out0 = 0, out1 = 0;
   bit   chk_lat = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [31:0] va, input logic [31:0] vb,
                                  input logic vbin, input int w);
      exp_t        e;
      logic [31:0] mask, am, bm;
      logic [32:0] full;
      mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      am     = va & mask;
      bm     = vb & mask;
      full   = {1'b0, am} - {1'b0, bm} - {32'b0, vbin};
      e.diff = full[31:0] & mask;
      e.bout = ({1'b0, am} < ({1'b0, bm} + {32'b0, vbin}));
      e.ovf  = (am[w-1] != bm[w-1]) && (e.diff[w-1] != am[w-1]);
      e.cyc  = 0;
      return e;
   endfunction

   // Accept recorder: reset discards everything still in flight.
   always @(posedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q0.delete();
         q1.delete();
      end else if (in_valid && in_ready0) begin
         e = model(a, b, bin, 32); e.cyc = cyc; q0.push_back(e);
         e = model(a, b, bin, 30); e.cyc = cyc; q1.push_back(e);
         acc++;
      end
      cyc++;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid0 && out_ready) begin
         if (q0.size() == 0) begin
            check_eq("dut32_spurious_valid", out_valid0, 1'b0);
         end else begin
            e = q0.pop_front();
            $display("dut32 result diff=%h bout=%b ovf=%b", diff0, bout0, ovf0);
            check_eq("dut32_diff", diff0, e.diff);
            check_eq("dut32_bout", bout0, e.bout);
            check_eq("dut32_ovf", ovf0, e.ovf);
            if (chk_lat) check_eq("dut32_latency", cyc - e.cyc, 8);
         end
         out0++;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid1 && out_ready) begin
         if (q1.size() == 0) begin
            check_eq("dut30_spurious_valid", out_valid1, 1'b0);
         end else begin
            e = q1.pop_front();
            $display("dut30 result diff=%h bout=%b ovf=%b", diff1, bout1, ovf1);
            check_eq("dut30_diff", diff1, e.diff);
            check_eq("dut30_bout", bout1, e.bout);
            check_eq("dut30_ovf", ovf1, e.ovf);
            if (chk_lat) check_eq("dut30_latency", cyc - e.cyc, 8);
         end
         out1++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_in();
      a   = $urandom;
      b   = $urandom;
      bin = 1'($urandom_range(0, 1));
   endtask

   // One operand set into an empty pipeline, hand-computed expectations for both widths.
   task automatic dir(input logic [31:0] va, input logic [31:0] vb, input logic vbin,
                      input logic [31:0] d32, input logic bo32, input logic ov32,
                      input logic [29:0] d30, input logic bo30, input logic ov30);
      int lat;
      a = va; b = vb; bin = vbin; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid0 && lat < 20);
      check_eq("dir_latency32", lat, 8);
      check_eq("dir_diff32", diff0, d32);
      check_eq("dir_bout32", bout0, bo32);
      check_eq("dir_ovf32", ovf0, ov32);
      check_eq("dir_valid30", out_valid1, 1'b1);
      check_eq("dir_diff30", diff1, d30);
      check_eq("dir_bout30", bout1, bo30);
      check_eq("dir_ovf30", ovf1, ov30);
      tick();
   endtask

   initial begin
      int          snap0, snap1;
      logic [31:0] hold0;
      logic [29:0] hold1;
      logic        hb0, ho0;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check_eq("rst_out_valid32", out_valid0, 1'b0);
      check_eq("rst_out_valid30", out_valid1, 1'b0);
      check_eq("rst_diff32", diff0, 32'h0);
      check_eq("rst_bout32", bout0, 1'b0);
      check_eq("rst_ovf32", ovf0, 1'b0);
      tick();
      rst_n = 1'b1;
      check_eq("post_rst_in_ready32", in_ready0, 1'b1);
      check_eq("post_rst_in_ready30", in_ready1, 1'b1);

      out_ready = 1'b1;
      chk_lat   = 1'b1;
      dir(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 30'h0000_0002, 1'b0, 1'b0);
      dir(32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 30'h3FFF_FFFF, 1'b1, 1'b0);
      dir(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 30'h3FFF_FFFF, 1'b1, 1'b0);
      dir(32'h2000_0000, 32'h0000_0001, 1'b0, 32'h1FFF_FFFF, 1'b0, 1'b0, 30'h1FFF_FFFF, 1'b0, 1'b1);
      dir(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 30'h0000_0000, 1'b0, 1'b0);

      // Back-to-back stream; per-result latency check proves one result per cycle.
      in_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         rand_in();
         tick();
      end
      in_valid = 1'b0;
      repeat (20) tick();
      check_eq("stream_left32", q0.size(), 0);
      check_eq("stream_left30", q1.size(), 0);
      check_eq("stream_count32", out0, acc);
      check_eq("stream_count30", out1, acc);
      chk_lat = 1'b0;

      // Fill, then hold the output back.
      in_valid = 1'b1;
      repeat (12) begin
         rand_in();
         tick();
      end
      out_ready = 1'b0;
      rand_in();
      @(negedge clk);
      hold0 = diff0; hold1 = diff1; hb0 = bout0; ho0 = ovf0;
      check_eq("stall_in_ready32", in_ready0, 1'b0);
      repeat (4) begin
         tick();
         rand_in();
         @(negedge clk);
         check_eq("stall_in_ready32", in_ready0, 1'b0);
         check_eq("stall_in_ready30", in_ready1, 1'b0);
         check_eq("stall_out_valid32", out_valid0, 1'b1);
         check_eq("stall_diff32", diff0, hold0);
         check_eq("stall_diff30", diff1, hold1);
         check_eq("stall_bout32", bout0, hb0);
         check_eq("stall_ovf32", ovf0, ho0);
      end
      tick();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      repeat (20) tick();
      check_eq("stall_left32", q0.size(), 0);
      check_eq("stall_left30", q1.size(), 0);
      check_eq("stall_count32", out0, acc);
      check_eq("stall_count30", out1, acc);

      // Four sets in flight, then a one-cycle reset.
      in_valid = 1'b1;
      repeat (4) begin
         rand_in();
         tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("midrst_out_valid32", out_valid0, 1'b0);
      check_eq("midrst_out_valid30", out_valid1, 1'b0);
      check_eq("midrst_in_ready32", in_ready0, 1'b1);
      snap0 = out0;
      snap1 = out1;
      repeat (20) tick();
      check_eq("midrst_no_emit32", out0, snap0);
      check_eq("midrst_no_emit30", out1, snap1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

endmodule
